arbiter_puf_ctrl: RTL and testbench

Sequencer for the 8-stage arbiter-PUF array. Latches a host challenge, drives it onto the delay-line selects, launches race pulses, and captures the 8 arbiter outputs. Repeats the evaluation and majority-votes each response bit to suppress metastable or noisy arbiters. Returns the voted response and a per-bit instability mask over a valid/ready handshake. Sits between the host register interface and the `arbiterpuf` instance; it replaces the free-running clock that would otherwise drive `ipulse`.

---
 rtl/puf_ctrl_pkg.sv | 29 ++
 rtl/puf_vote_counter.sv | 57 +++++
 rtl/arbiter_puf_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_arbiter_puf_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// puf_ctrl_pkg
// Shared definitions for the arbiter-PUF sequencer:
//   - state_t   : sequencer states
//   - DEF_*     : default parameter values
//   - vote_w()  : width of a per-bit vote counter able to hold 0..num_eval
// -----------------------------------------------------------------------------
package puf_ctrl_pkg;

  localparam int DEF_CHAL_W     = 8;
  localparam int DEF_RESP_W     = 8;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 4;
  localparam int DEF_NUM_EVAL   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FIRE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // A counter must represent every value from 0 up to num_eval inclusive.
  function automatic int vote_w(input int num_eval);
    return (num_eval < 1) ? 1 : $clog2(num_eval + 1);
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// -----------------------------------------------------------------------------
// puf_vote_counter
// Counts how many evaluations returned 1 for a single arbiter and reports the
// majority and disagreement flags. The flags are derived from the count
// *including* the sample presented this cycle, so the parent can register the
// final verdict on the same edge that takes the last sample.
//
// Parameters: NUM_EVAL - evaluations per challenge (odd, >= 1)
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - zero the count (new challenge)
//   inc_en      - a sample is being taken this cycle
//   sample      - arbiter output for this evaluation
//   majority    - count (incl. current sample) > NUM_EVAL/2
//   unstable    - count (incl. current sample) is neither 0 nor NUM_EVAL
// -----------------------------------------------------------------------------
module puf_vote_counter
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_EVAL = DEF_NUM_EVAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc_en,
  input  logic sample,
  output logic majority,
  output logic unstable
);

  localparam int VW = vote_w(NUM_EVAL);

  logic [VW-1:0] count;
  logic [VW-1:0] count_nxt;

  // Saturating: the count never wraps even if extra samples were requested.
  always_comb begin
    count_nxt = count;
    if (inc_en && sample && (count != VW'(NUM_EVAL))) begin
      count_nxt = count + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc_en) begin
      count <= count_nxt;
    end
  end

  assign majority = (count_nxt > VW'(NUM_EVAL / 2));
  assign unstable = (count_nxt != '0) && (count_nxt != VW'(NUM_EVAL));

endmodule

// File: rtl/arbiter_puf_ctrl.sv
// -----------------------------------------------------------------------------
// arbiter_puf_ctrl
// Sequencer for the arbiter-PUF array. Latches a host challenge, drives it on
// the delay-line selects, generates the race pulse (low SETTLE_CYC cycles,
// high HOLD_CYC+1 cycles), captures the arbiter outputs on the last high cycle
// and repeats NUM_EVAL times. Each response bit is majority-voted and a
// per-bit instability mask is returned over a valid/ready handshake.
//
// Build option: define PUF_MAJORITY_EN to enable repeated evaluation with
// voting. Without it a single evaluation is done, response_o is that capture
// and unstable_o is always 0.
//
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   start_i          - request evaluation of challenge_i (honoured in IDLE only)
//   challenge_i      - host challenge
//   busy_o           - evaluation in progress
//   resp_valid_o     - result available; held until resp_ready_i
//   resp_ready_i     - host accepts result
//   response_o       - voted response
//   unstable_o       - bit i set when arbiter i disagreed across evaluations
//   puf_challenge_o  - to array ichallenge
//   puf_pulse_o      - to array ipulse
//   puf_response_i   - from array oresponse
// -----------------------------------------------------------------------------
module arbiter_puf_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W     = DEF_CHAL_W,
  parameter int RESP_W     = DEF_RESP_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int NUM_EVAL   = DEF_NUM_EVAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CHAL_W-1:0] challenge_i,
  output logic              busy_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [RESP_W-1:0] response_o,
  output logic [RESP_W-1:0] unstable_o,
  output logic [CHAL_W-1:0] puf_challenge_o,
  output logic              puf_pulse_o,
  input  logic [RESP_W-1:0] puf_response_i
);

`ifdef PUF_MAJORITY_EN
  localparam bit MAJ_EN = 1'b1;
`else
  localparam bit MAJ_EN = 1'b0;
`endif

  localparam int EFF_EVAL = MAJ_EN ? NUM_EVAL : 1;
  localparam int EV_W     = (EFF_EVAL > 1) ? $clog2(EFF_EVAL) : 1;
  localparam int CYC_MAX  = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int CYC_W    = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  cyc_cnt, cyc_nxt;
  logic [EV_W-1:0]   eval_cnt, eval_nxt;
  logic              busy_nxt, valid_nxt, pulse_nxt;
  logic [CHAL_W-1:0] chal_nxt;
  logic [RESP_W-1:0] resp_nxt, unst_nxt;

  // Verdict that would be registered if this were the final SAMPLE cycle.
  logic [RESP_W-1:0] verdict_resp, verdict_unst;

`ifdef PUF_MAJORITY_EN
  logic vote_clear;
  logic vote_inc;

  for (genvar i = 0; i < RESP_W; i++) begin : g_vote
    puf_vote_counter #(
      .NUM_EVAL (EFF_EVAL)
    ) u_vote (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (vote_clear),
      .inc_en   (vote_inc),
      .sample   (puf_response_i[i]),
      .majority (verdict_resp[i]),
      .unstable (verdict_unst[i])
    );
  end

  assign vote_clear = (state == ST_IDLE) && start_i;
  assign vote_inc   = (state == ST_SAMPLE);
`else
  assign verdict_resp = puf_response_i;
  assign verdict_unst = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    eval_nxt  = eval_cnt;
    busy_nxt  = busy_o;
    valid_nxt = resp_valid_o;
    pulse_nxt = puf_pulse_o;
    chal_nxt  = puf_challenge_o;
    resp_nxt  = response_o;
    unst_nxt  = unstable_o;

    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          chal_nxt  = challenge_i;
          cyc_nxt   = '0;
          eval_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) begin
          cyc_nxt   = '0;
          pulse_nxt = 1'b1;  // rising edge launches the race
          state_nxt = ST_FIRE;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end

      ST_FIRE: begin
        if (cyc_cnt == CYC_W'(HOLD_CYC - 1)) begin
          cyc_nxt   = '0;
          state_nxt = ST_SAMPLE;
        end else begin
          cyc_nxt = cyc_cnt + CYC_W'(1);
        end
      end

      ST_SAMPLE: begin
        // Pulse drops on leaving SAMPLE: either the next SETTLE or DONE.
        pulse_nxt = 1'b0;
        if (eval_cnt == EV_W'(EFF_EVAL - 1)) begin
          resp_nxt  = verdict_resp;
          unst_nxt  = verdict_unst;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end else begin
          eval_nxt  = eval_cnt + EV_W'(1);
          state_nxt = ST_SETTLE;
        end
      end

      ST_DONE: begin
        if (resp_ready_i) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt         <= '0;
      eval_cnt        <= '0;
      busy_o          <= 1'b0;
      resp_valid_o    <= 1'b0;
      puf_pulse_o     <= 1'b0;
      puf_challenge_o <= '0;
      response_o      <= '0;
      unstable_o      <= '0;
    end else begin
      cyc_cnt         <= cyc_nxt;
      eval_cnt        <= eval_nxt;
      busy_o          <= busy_nxt;
      resp_valid_o    <= valid_nxt;
      puf_pulse_o     <= pulse_nxt;
      puf_challenge_o <= chal_nxt;
      response_o      <= resp_nxt;
      unstable_o      <= unst_nxt;
    end
  end

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arbiter_puf_ctrl
// Self-checking bench for arbiter_puf_ctrl. A behavioural array model hands
// out one queued response word per race pulse; expected results are computed
// by counting ones per bit over the evaluations of a challenge.
// -----------------------------------------------------------------------------
module tb_arbiter_puf_ctrl;

  localparam int CHAL_W     = 8;
  localparam int RESP_W     = 8;
  localparam int SETTLE_CYC = 4;
  localparam int HOLD_CYC   = 4;
  localparam int NUM_EVAL   = 7;
`ifdef PUF_MAJORITY_EN
  localparam int N_EVAL = NUM_EVAL;
`else
  localparam int N_EVAL = 1;
`endif
  localparam int P   = SETTLE_CYC + HOLD_CYC + 1;
  localparam int LAT = N_EVAL * P;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CHAL_W-1:0] challenge;
  logic              busy;
  logic              resp_valid;
  logic              resp_ready;
  logic [RESP_W-1:0] response;
  logic [RESP_W-1:0] unstable;
  logic [CHAL_W-1:0] puf_challenge;
  logic              puf_pulse;
  logic [RESP_W-1:0] puf_response;

  int total = 0;
  int bad   = 0;

  logic [RESP_W-1:0] eval_q[$];

  arbiter_puf_ctrl #(
    .CHAL_W     (CHAL_W),
    .RESP_W     (RESP_W),
    .SETTLE_CYC (SETTLE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .NUM_EVAL   (NUM_EVAL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .challenge_i     (challenge),
    .busy_o          (busy),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .response_o      (response),
    .unstable_o      (unstable),
    .puf_challenge_o (puf_challenge),
    .puf_pulse_o     (puf_pulse),
    .puf_response_i  (puf_response)
  );

  always #5 clk = ~clk;

  // Array model: each race yields the next queued word; between races the
  // outputs are garbage so only the real sample point may be used.
  always @(posedge puf_pulse) begin
    if (eval_q.size() > 0) puf_response = eval_q.pop_front();
    else                   puf_response = RESP_W'($urandom);
  end
  always @(negedge puf_pulse) puf_response = RESP_W'($urandom);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(input string name, input logic [63:0] got, input logic [63:0] exp);
    bad++;
    $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: majority = more than half the evaluations read 1.
  task automatic model(input logic [RESP_W-1:0] s [N_EVAL],
                       output logic [RESP_W-1:0] r, output logic [RESP_W-1:0] u);
    for (int b = 0; b < RESP_W; b++) begin
      int ones = 0;
      for (int e = 0; e < N_EVAL; e++) ones += int'(s[e][b]);
      r[b] = (ones > N_EVAL / 2);
      u[b] = (ones != 0) && (ones != N_EVAL);
    end
  endtask

  // Runs one challenge to DONE (resp_ready held low) and checks timing,
  // pulse shape, challenge stability and the voted result.
  task automatic do_eval(input string tag, input logic [CHAL_W-1:0] chal,
                         input logic [RESP_W-1:0] s [N_EVAL],
                         output logic [RESP_W-1:0] er, output logic [RESP_W-1:0] eu);
    int   cyc, hi, rises, run;
    logic prev, chal_ok;
    model(s, er, eu);
    eval_q.delete();
    for (int e = 0; e < N_EVAL; e++) eval_q.push_back(s[e]);
    resp_ready = 1'b0;
    challenge  = chal;
    start      = 1'b1;
    tick();
    start     = 1'b0;
    challenge = ~chal;
    total++; if (busy !== 1'b1) fail({tag, " busy@t0"}, 64'(busy), 64'(1));
    total++; if (puf_challenge !== chal) fail({tag, " chal@t0"}, 64'(puf_challenge), 64'(chal));
    cyc = 0; hi = 0; rises = 0; run = 0; prev = 1'b0; chal_ok = 1'b1;
    while (resp_valid !== 1'b1 && cyc < LAT + 20) begin
      tick();
      cyc++;
      if (puf_pulse === 1'b1) begin
        hi++;
        run++;
        if (!prev) rises++;
      end else if (prev) begin
        total++; if (run != HOLD_CYC + 1) fail({tag, " pulse_width"}, 64'(run), 64'(HOLD_CYC + 1));
        run = 0;
      end
      prev = puf_pulse;
      if (puf_challenge !== chal) chal_ok = 1'b0;
    end
    total++; if (cyc != LAT) fail({tag, " latency"}, 64'(cyc), 64'(LAT));
    total++; if (rises != N_EVAL) fail({tag, " pulse_count"}, 64'(rises), 64'(N_EVAL));
    total++; if (hi != N_EVAL * (HOLD_CYC + 1)) fail({tag, " pulse_high"}, 64'(hi), 64'(N_EVAL * (HOLD_CYC + 1)));
    total++; if (chal_ok !== 1'b1) fail({tag, " chal_stable"}, 64'(chal_ok), 64'(1));
    total++; if (response !== er) fail({tag, " response"}, 64'(response), 64'(er));
    total++; if (unstable !== eu) fail({tag, " unstable"}, 64'(unstable), 64'(eu));
    total++; if ({busy, puf_pulse} !== 2'b00) fail({tag, " busy_pulse@done"}, 64'({busy, puf_pulse}), 64'(0));
  endtask

  task automatic release_result(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total++; if ({resp_valid, busy} !== 2'b00) fail({tag, " release"}, 64'({resp_valid, busy}), 64'(0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; resp_ready = 1'b0; challenge = '0; puf_response = '0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if ({busy, resp_valid, puf_pulse} !== 3'b000) fail("reset flags", 64'({busy, resp_valid, puf_pulse}), 64'(0));
    total++; if ({response, unstable, puf_challenge} !== '0) fail("reset data", 64'({response, unstable, puf_challenge}), 64'(0));
  endtask

  task automatic test_stable();
    logic [RESP_W-1:0] s [N_EVAL];
    logic [RESP_W-1:0] er, eu;
    for (int e = 0; e < N_EVAL; e++) s[e] = 8'h3C;
    do_eval("stable", 8'hA5, s, er, eu);
    total++; if (response !== 8'h3C) fail("stable const_resp", 64'(response), 64'h3C);
    release_result("stable");
  endtask

  task automatic test_noisy();
    logic [RESP_W-1:0] s [N_EVAL];
    logic [RESP_W-1:0] er, eu;
    // bit 0 high on evaluations 1,3,5; bit 7 high on 0,2,4,6
    for (int e = 0; e < N_EVAL; e++) begin
      s[e] = '0;
      s[e][0] = (e % 2 == 1);
      s[e][7] = (e % 2 == 0);
    end
    do_eval("noisy", 8'h5A, s, er, eu);
    release_result("noisy");
  endtask

  task automatic test_random();
    logic [RESP_W-1:0] s [N_EVAL];
    logic [RESP_W-1:0] er, eu, base;
    for (int k = 0; k < 4; k++) begin
      base = RESP_W'($urandom);
      for (int e = 0; e < N_EVAL; e++) s[e] = base ^ RESP_W'($urandom & $urandom & $urandom);
      do_eval("random", CHAL_W'($urandom), s, er, eu);
      release_result("random");
    end
  endtask

  task automatic test_hold_done();
    logic [RESP_W-1:0] s [N_EVAL];
    logic [RESP_W-1:0] er, eu;
    logic [CHAL_W-1:0] chal;
    logic [2*RESP_W+CHAL_W+2:0] exp_v;
    chal = 8'hC3;
    for (int e = 0; e < N_EVAL; e++) s[e] = RESP_W'($urandom);
    do_eval("hold", chal, s, er, eu);
    exp_v = {1'b1, 1'b0, 1'b0, chal, er, eu};
    for (int c = 0; c < 20; c++) begin
      start     = 1'($urandom);
      challenge = CHAL_W'($urandom);
      tick();
      total++;
      if ({resp_valid, busy, puf_pulse, puf_challenge, response, unstable} !== exp_v)
        fail("hold outputs", 64'({resp_valid, busy, puf_pulse, puf_challenge, response, unstable}), 64'(exp_v));
    end
    start = 1'b0;
    release_result("hold");
    tick();
    total++; if ({busy, puf_pulse} !== 2'b00) fail("hold idle", 64'({busy, puf_pulse}), 64'(0));
    total++; if ({response, unstable} !== {er, eu}) fail("hold keep", 64'({response, unstable}), 64'({er, eu}));
  endtask

  task automatic test_reset_mid_fire();
    logic [RESP_W-1:0] s [N_EVAL];
    logic [RESP_W-1:0] er, eu;
    int hi, cyc;
    challenge = 8'h96;
    start     = 1'b1;
    tick();
    start = 1'b0;
    hi = 0; cyc = 0;
    while (hi < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (puf_pulse === 1'b1) hi++;
    end
    total++; if (hi != 3) fail("rstmid reach_fire", 64'(hi), 64'(3));
    rst_n = 1'b0;
    #1;
    total++; if (puf_pulse !== 1'b0) fail("rstmid pulse_drop", 64'(puf_pulse), 64'(0));
    total++;
    if ({busy, resp_valid, puf_challenge, response, unstable} !== '0)
      fail("rstmid outputs", 64'({busy, resp_valid, puf_challenge, response, unstable}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int e = 0; e < N_EVAL; e++) s[e] = RESP_W'($urandom);
    do_eval("after_rst", 8'h69, s, er, eu);
    release_result("after_rst");
  endtask

  task automatic test_back_to_back();
    logic [RESP_W-1:0] s [N_EVAL];
    logic [RESP_W-1:0] er [3];
    logic [RESP_W-1:0] eu [3];
    int   acc [3];
    int   n_acc, n_res, n_valid, cyc;
    logic prev_busy;
    eval_q.delete();
    for (int k = 0; k < 3; k++) begin
      for (int e = 0; e < N_EVAL; e++) begin
        s[e] = RESP_W'($urandom) & RESP_W'($urandom);
        eval_q.push_back(s[e]);
      end
      model(s, er[k], eu[k]);
    end
    resp_ready = 1'b1;
    start      = 1'b1;
    n_acc = 0; n_res = 0; n_valid = 0; cyc = 0; prev_busy = 1'b0;
    while (n_res < 3 && cyc < 4 * (LAT + 2) + 20) begin
      challenge = CHAL_W'($urandom);
      tick();
      cyc++;
      if (busy === 1'b1 && !prev_busy && n_acc < 3) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      prev_busy = busy;
      if (resp_valid === 1'b1) begin
        n_valid++;
        total++; if (response !== er[n_res]) fail("b2b response", 64'(response), 64'(er[n_res]));
        total++; if (unstable !== eu[n_res]) fail("b2b unstable", 64'(unstable), 64'(eu[n_res]));
        n_res++;
        if (n_res == 3) start = 1'b0;
      end
    end
    tick();
    total++; if (n_acc != 3) fail("b2b accepts", 64'(n_acc), 64'(3));
    total++; if (n_valid != 3) fail("b2b valid_cycles", 64'(n_valid), 64'(3));
    total++; if (resp_valid !== 1'b0) fail("b2b valid_drop", 64'(resp_valid), 64'(0));
    if (n_acc == 3) begin
      total++; if (acc[1] - acc[0] != LAT + 2) fail("b2b spacing0", 64'(acc[1] - acc[0]), 64'(LAT + 2));
      total++; if (acc[2] - acc[1] != LAT + 2) fail("b2b spacing1", 64'(acc[2] - acc[1]), 64'(LAT + 2));
    end
    resp_ready = 1'b0;
    tick();
    total++; if (busy !== 1'b0) fail("b2b idle", 64'(busy), 64'(0));
  endtask

  initial begin
    test_reset();
    test_stable();
    test_noisy();
    test_random();
    test_hold_done();
    test_reset_mid_fire();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
